// File: rtl/led_matrix_scanner_if.sv
// CPU-side and display-side signals of the LED matrix scanner.
// The master drives control, frame writes and swap requests; the slave drives the matrix.
interface led_matrix_scanner_if #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned PWM_BITS = 2
);
   localparam int unsigned RW = $clog2(ROWS);

   logic                en;
   logic [PWM_BITS-1:0] bright;
   logic                wr_en;
   logic [RW-1:0]       wr_row;
   logic [COLS-1:0]     wr_data;
   logic                swap_req;
   logic                swap_ack;
   logic                frame_start;
   logic [ROWS-1:0]     row;
   logic [COLS-1:0]     col;

   modport master (
      output en, bright, wr_en, wr_row, wr_data, swap_req,
      input  swap_ack, frame_start, row, col
   );

   modport slave (
      input  en, bright, wr_en, wr_row, wr_data, swap_req,
      output swap_ack, frame_start, row, col
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// Multiplexed dot-matrix scanner with a double-buffered frame store and global PWM brightness.
// Bank swaps happen only at the frame boundary so a displayed frame never tears.
module led_matrix_scanner #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned DIV      = 4,
  parameter int unsigned PWM_BITS = 2
) (
   input logic                 clk,
   input logic                 reset,
   led_matrix_scanner_if.slave bus
);
   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DivMax = DW'(DIV - 1);
   localparam logic [RW-1:0] RowMax = RW'(ROWS - 1);

   logic [COLS-1:0]     mem_q [2][ROWS];
   logic                front_q, front_d;
   logic                pending_q, pending_d;
   logic [DW-1:0]       div_cnt_q, div_cnt_d;
   logic [PWM_BITS-1:0] slot_q, slot_d;
   logic [RW-1:0]       row_idx_q, row_idx_d;
   logic [ROWS-1:0]     row_q, row_d;
   logic [COLS-1:0]     col_q, col_d;
   logic                swap_ack_q, swap_ack_d;
   logic                frame_start_q, frame_start_d;
   logic                tick, slot_wrap, boundary, swap, wr_ok;

   always_comb begin
      tick      = bus.en && (div_cnt_q == DivMax);
      slot_wrap = tick && (slot_q == '1);
      boundary  = slot_wrap && (row_idx_q == RowMax);
      swap      = boundary && (pending_q || bus.swap_req);
      wr_ok     = bus.wr_en && (32'(bus.wr_row) < ROWS);

      div_cnt_d = div_cnt_q;
      slot_d    = slot_q;
      row_idx_d = row_idx_q;
      if (bus.en) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
         if (tick) slot_d = slot_q + 1'b1;
         if (slot_wrap) row_idx_d = boundary ? '0 : row_idx_q + 1'b1;
      end

      front_d    = front_q ^ swap;
      // A request arriving in the boundary cycle is consumed by that same swap.
      pending_d  = (pending_q || bus.swap_req) && !boundary;
      swap_ack_d = swap;

      row_d         = '0;
      col_d         = '1;
      frame_start_d = 1'b0;
      if (bus.en) begin
         row_d = {{(ROWS - 1){1'b0}}, 1'b1} << row_idx_q;
         if (slot_q <= bus.bright) col_d = ~mem_q[front_q][row_idx_q];
         frame_start_d = (row_idx_q == '0) && (slot_q == '0) && (div_cnt_q == '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) mem_q[b][r] <= '0;
         end
         front_q       <= 1'b0;
         pending_q     <= 1'b0;
         div_cnt_q     <= '0;
         slot_q        <= '0;
         row_idx_q     <= '0;
         row_q         <= '0;
         col_q         <= '1;
         swap_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // Back bank is indexed by the pre-swap front, so a write on the swap edge shows next frame.
         if (wr_ok) mem_q[~front_q][bus.wr_row] <= bus.wr_data;
         front_q       <= front_d;
         pending_q     <= pending_d;
         div_cnt_q     <= div_cnt_d;
         slot_q        <= slot_d;
         row_idx_q     <= row_idx_d;
         row_q         <= row_d;
         col_q         <= col_d;
         swap_ack_q    <= swap_ack_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.row         = row_q;
   assign bus.col         = col_q;
   assign bus.swap_ack    = swap_ack_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: an 8-row instance for scan, PWM, swap and enable
// behaviour, and a 6-row instance for out-of-range row writes.
module tb_led_matrix_scanner;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   led_matrix_scanner_if #(.ROWS(8), .COLS(8), .PWM_BITS(2)) a_if ();
   led_matrix_scanner_if #(.ROWS(6), .COLS(8), .PWM_BITS(2)) b_if ();

   led_matrix_scanner #(.ROWS(8), .COLS(8), .DIV(4), .PWM_BITS(2)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   led_matrix_scanner #(.ROWS(6), .COLS(8), .DIV(4), .PWM_BITS(2)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stepn(input int n);
      repeat (n) step();
   endtask

   // Leaves the bench just after the edge on which A's frame_start is high (scan position 0).
   task automatic sync_a();
      bit found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (a_if.frame_start) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL sync_frame: frame_start not seen within 300 cycles");
      end
   endtask

   task automatic write_a(input logic [2:0] r, input logic [7:0] d);
      a_if.wr_en   = 1'b1;
      a_if.wr_row  = r;
      a_if.wr_data = d;
      step();
      a_if.wr_en = 1'b0;
   endtask

   task automatic swap_a();
      bit found = 1'b0;
      a_if.swap_req = 1'b1;
      step();
      a_if.swap_req = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (a_if.swap_ack) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL swap_wait: swap_ack not seen within 300 cycles");
      end
   endtask

   task automatic test_reset();
      int acks = 0;
      stepn(2);
      checks++;
      if ({a_if.row, a_if.col, a_if.swap_ack, a_if.frame_start} !== {8'h00, 8'hFF, 2'b00}) begin
         failures++;
         $display("FAIL reset_outputs: row=%h col=%h ack=%b fs=%b, want 00 ff 0 0",
                  a_if.row, a_if.col, a_if.swap_ack, a_if.frame_start);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({a_if.frame_start, a_if.row, a_if.col} !== {1'b1, 8'h01, 8'hFF}) begin
         failures++;
         $display("FAIL first_frame: fs=%b row=%h col=%h, want 1 01 ff",
                  a_if.frame_start, a_if.row, a_if.col);
      end
      stepn(50);
      a_if.swap_req = 1'b1;
      step();
      a_if.swap_req = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({a_if.row, a_if.col, a_if.swap_ack} !== {8'h00, 8'hFF, 1'b0}) begin
         failures++;
         $display("FAIL midscan_reset: row=%h col=%h ack=%b, want 00 ff 0",
                  a_if.row, a_if.col, a_if.swap_ack);
      end
      step();
      reset = 1'b1;
      step();
      checks++;
      if ({a_if.frame_start, a_if.row} !== {1'b1, 8'h01}) begin
         failures++;
         $display("FAIL restart_frame: fs=%b row=%h, want 1 01", a_if.frame_start, a_if.row);
      end
      for (int i = 0; i < 200; i++) begin
         step();
         if (a_if.swap_ack) acks++;
      end
      checks++;
      if (acks != 0) begin
         failures++;
         $display("FAIL reset_drops_pending: acks=%0d, want 0", acks);
      end
   endtask

   task automatic test_write_swap();
      write_a(3'd2, 8'hA5);
      sync_a();
      stepn(32);
      checks++;
      if ({a_if.row, a_if.col} !== {8'h04, 8'hFF}) begin
         failures++;
         $display("FAIL write_hidden: row=%h col=%h, want 04 ff", a_if.row, a_if.col);
      end
      swap_a();
      step();
      checks++;
      if ({a_if.frame_start, a_if.swap_ack} !== 2'b10) begin
         failures++;
         $display("FAIL ack_then_frame: fs=%b ack=%b, want 1 0", a_if.frame_start, a_if.swap_ack);
      end
      stepn(32);
      checks++;
      if ({a_if.row, a_if.col} !== {8'h04, 8'h5A}) begin
         failures++;
         $display("FAIL swapped_row2: row=%h col=%h, want 04 5a", a_if.row, a_if.col);
      end
   endtask

   task automatic test_pwm();
      logic [15:0] pat;
      logic [15:0] want;
      int          len;
      write_a(3'd1, 8'hFF);
      swap_a();
      for (int b = 0; b < 4; b++) begin
         a_if.bright = 2'(b);
         sync_a();
         stepn(15);
         pat = '0;
         for (int i = 0; i < 16; i++) begin
            step();
            pat[i] = (a_if.row == 8'h02) && (a_if.col == 8'h00);
         end
         want = 16'((1 << (4 * (b + 1))) - 1);
         checks++;
         if (pat !== want) begin
            failures++;
            $display("FAIL pwm_duty b=%0d: lit=%h, want %h", b, pat, want);
         end
      end
      a_if.bright = 2'd0;
      sync_a();
      stepn(20);
      checks++;
      if (a_if.col !== 8'hFF) begin
         failures++;
         $display("FAIL pwm_dim_slot1: col=%h, want ff", a_if.col);
      end
      a_if.bright = 2'd1;
      step();
      checks++;
      if (a_if.col !== 8'h00) begin
         failures++;
         $display("FAIL bright_live: col=%h, want 00", a_if.col);
      end
      a_if.bright = 2'd3;
      sync_a();
      stepn(32);
      checks++;
      if ({a_if.row, a_if.col} !== {8'h04, 8'hFF}) begin
         failures++;
         $display("FAIL no_copy: row=%h col=%h, want 04 ff", a_if.row, a_if.col);
      end
      sync_a();
      len = 0;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (a_if.frame_start) begin
            len = i;
            break;
         end
      end
      checks++;
      if (len != 128) begin
         failures++;
         $display("FAIL frame_period: got %0d, want 128", len);
      end
   endtask

   task automatic test_swap_timing();
      int acks = 0;
      sync_a();
      for (int i = 1; i <= 300; i++) begin
         a_if.swap_req = (i == 10) || (i == 40) || (i == 90);
         step();
         if (a_if.swap_ack) acks++;
      end
      a_if.swap_req = 1'b0;
      checks++;
      if (acks != 1) begin
         failures++;
         $display("FAIL swap_merge: acks=%0d, want 1", acks);
      end
      sync_a();
      stepn(32);
      checks++;
      if ({a_if.row, a_if.col} !== {8'h04, 8'h5A}) begin
         failures++;
         $display("FAIL merged_bank: row=%h col=%h, want 04 5a", a_if.row, a_if.col);
      end
      // Request and write both land on the boundary edge itself.
      sync_a();
      stepn(126);
      a_if.swap_req = 1'b1;
      a_if.wr_en    = 1'b1;
      a_if.wr_row   = 3'd3;
      a_if.wr_data  = 8'h81;
      step();
      a_if.swap_req = 1'b0;
      a_if.wr_en    = 1'b0;
      checks++;
      if (a_if.swap_ack !== 1'b1) begin
         failures++;
         $display("FAIL boundary_swap: ack=%b, want 1", a_if.swap_ack);
      end
      step();
      checks++;
      if (a_if.frame_start !== 1'b1) begin
         failures++;
         $display("FAIL boundary_frame: fs=%b, want 1", a_if.frame_start);
      end
      stepn(16);
      checks++;
      if ({a_if.row, a_if.col} !== {8'h02, 8'h00}) begin
         failures++;
         $display("FAIL boundary_row1: row=%h col=%h, want 02 00", a_if.row, a_if.col);
      end
      stepn(32);
      checks++;
      if ({a_if.row, a_if.col} !== {8'h08, 8'h7E}) begin
         failures++;
         $display("FAIL swap_edge_write: row=%h col=%h, want 08 7e", a_if.row, a_if.col);
      end
   endtask

   task automatic test_enable_hold();
      int bad    = 0;
      int fs_pos = 0;
      sync_a();
      for (int i = 1; i <= 200; i++) begin
         a_if.en = !((i >= 90) && (i <= 126));
         step();
         if ((i >= 90) && (i <= 126) && ({a_if.row, a_if.col} !== {8'h00, 8'hFF})) bad++;
         if ((i == 127) || (i == 132)) begin
            checks++;
            if (a_if.row !== 8'h20) begin
               failures++;
               $display("FAIL resume_row5 i=%0d: row=%h, want 20", i, a_if.row);
            end
         end
         if (i == 133) begin
            checks++;
            if (a_if.row !== 8'h40) begin
               failures++;
               $display("FAIL resume_slot: row=%h, want 40", a_if.row);
            end
         end
         if (a_if.frame_start && (fs_pos == 0)) fs_pos = i;
      end
      a_if.en = 1'b1;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL enable_blank: bad cycles=%0d, want 0", bad);
      end
      checks++;
      if (fs_pos != 165) begin
         failures++;
         $display("FAIL enable_extend: frame length=%0d, want 165", fs_pos);
      end
   endtask

   task automatic swap_b_and_sync(output bit ok);
      ok = 1'b0;
      b_if.swap_req = 1'b1;
      step();
      b_if.swap_req = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (b_if.swap_ack) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      step();
      ok = ok && b_if.frame_start;
   endtask

   task automatic test_boundary_writes();
      bit ok;
      int bad = 0;
      b_if.wr_en   = 1'b1;
      b_if.wr_data = 8'hFF;
      b_if.wr_row  = 3'd6;
      step();
      b_if.wr_row = 3'd7;
      step();
      b_if.wr_en = 1'b0;
      swap_b_and_sync(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL b_swap1: swap/frame_start not observed");
      end
      for (int i = 1; i < 96; i++) begin
         step();
         if ((b_if.col !== 8'hFF) || (b_if.row == 6'h00)) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL b_oob_write: bad cycles=%0d, want 0", bad);
      end
      step();
      checks++;
      if (b_if.frame_start !== 1'b1) begin
         failures++;
         $display("FAIL b_frame_period: fs=%b at cycle 96, want 1", b_if.frame_start);
      end
      b_if.wr_en   = 1'b1;
      b_if.wr_row  = 3'd5;
      b_if.wr_data = 8'h11;
      step();
      b_if.wr_en = 1'b0;
      swap_b_and_sync(ok);
      stepn(80);
      checks++;
      if (!ok || ({b_if.row, b_if.col} !== {6'h20, 8'hEE})) begin
         failures++;
         $display("FAIL b_row5: ok=%b row=%h col=%h, want 1 20 ee", ok, b_if.row, b_if.col);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b0;
      a_if.en       = 1'b1;
      a_if.bright   = 2'd3;
      a_if.wr_en    = 1'b0;
      a_if.wr_row   = '0;
      a_if.wr_data  = '0;
      a_if.swap_req = 1'b0;
      b_if.en       = 1'b1;
      b_if.bright   = 2'd3;
      b_if.wr_en    = 1'b0;
      b_if.wr_row   = '0;
      b_if.wr_data  = '0;
      b_if.swap_req = 1'b0;
      test_reset();
      test_write_swap();
      test_pwm();
      test_swap_timing();
      test_enable_hold();
      test_boundary_writes();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
